clk_div_sched: RTL and testbench

- Owns the shared programmable clock divider in the RFID baseband.
- Requesters such as the TX backscatter encoder (BLF) and the RX PIE decoder (Tari sampling) each ask for the divider at their own ratio; the block gives it to one requester at a time in round-robin order.
- For each grant it loads the ratio, starts the divider, confirms that the divider output toggles, and holds the grant until the owner releases it.
- After release it stops the divider and waits a guard interval before the next owner.

---
 rtl/clk_div_sched.sv | 123 ++++++++++++
 tb/tb_clk_div_sched.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_sched.sv
// Round-robin scheduler for the shared baseband clock divider: grants one requester
// at a time, loads its ratio, confirms div_out toggles, and enforces a guard gap between owners.
module clk_div_sched #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned RW      = 9,
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned GUARD   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*RW-1:0]   req_ratio,
    output logic [NREQ-1:0]      grant,
    output logic                 locked,
    output logic                 err_timeout,
    output logic                 div_enable,
    output logic [RW-1:0]        div_ratio,
    input  logic                 div_out
);

    localparam int unsigned IW         = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CMAX       = (TIMEOUT > GUARD) ? TIMEOUT : GUARD;
    localparam int unsigned CW         = $clog2(CMAX + 1);
    localparam int unsigned TO_LAST    = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam int unsigned GUARD_LAST = (GUARD > 0) ? GUARD - 1 : 0;

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, STOP} state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [CW-1:0]   cnt;
    logic            div_sample;

    logic            win_valid_c;
    logic [IW-1:0]   win_idx_c;
    logic [IW-1:0]   next_ptr_c;
    logic            owner_req_c;
    logic            toggled_c;
    logic            timeout_c;
    logic            go_stop_c;

    // First set request at or above rr_ptr, wrapping; lowest offset is assigned last and wins.
    always_comb begin
        win_valid_c = 1'b0;
        win_idx_c   = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % int'(NREQ)]) begin
                win_valid_c = 1'b1;
                win_idx_c   = IW'((int'(rr_ptr) + k) % int'(NREQ));
            end
        end
    end

    assign next_ptr_c  = (int'(owner) == int'(NREQ) - 1) ? '0 : owner + IW'(1);
    assign owner_req_c = req[owner];
    assign toggled_c   = (div_out != div_sample);
    assign timeout_c   = (cnt >= CW'(TO_LAST));

    // Owner release beats both lock detection and timeout.
    assign go_stop_c = (((state == START) || (state == RUN)) && !owner_req_c)
                     || ((state == START) && !toggled_c && timeout_c);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            locked      <= 1'b0;
            err_timeout <= 1'b0;
            div_enable  <= 1'b0;
            div_ratio   <= '0;
            rr_ptr      <= '0;
            owner       <= '0;
            cnt         <= '0;
            div_sample  <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    div_enable <= 1'b0;
                    if (win_valid_c) begin
                        owner <= win_idx_c;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    div_ratio  <= req_ratio[int'(owner) * RW +: RW];
                    grant      <= NREQ'(1) << owner;
                    cnt        <= '0;
                    div_sample <= div_out;
                    div_enable <= 1'b1;
                    state      <= START;
                end
                START: begin
                    if (cnt != CW'(CMAX)) cnt <= cnt + CW'(1);
                    if (owner_req_c && toggled_c) begin
                        locked <= 1'b1;
                        state  <= RUN;
                    end else if (owner_req_c && timeout_c) begin
                        err_timeout <= 1'b1;
                    end
                end
                RUN: begin
                end
                STOP: begin
                    if (cnt >= CW'(GUARD_LAST)) state <= IDLE;
                    else                        cnt   <= cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
            // Leaving an ownership: disable divider, drop grant, advance the pointer, start guard.
            if (go_stop_c) begin
                div_enable <= 1'b0;
                locked     <= 1'b0;
                grant      <= '0;
                rr_ptr     <= next_ptr_c;
                cnt        <= '0;
                state      <= STOP;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_sched.sv
// Bench for clk_div_sched: behavioural divider plus scenario tasks and a randomized
// round-robin reference model.
module tb_clk_div_sched;

    localparam int unsigned NREQ    = 2;
    localparam int unsigned RW      = 9;
    localparam int unsigned TIMEOUT = 1023;
    localparam int unsigned GUARD   = 4;
    localparam int          NR      = int'(NREQ);

    logic                 clock     = 1'b0;
    logic                 reset     = 1'b1;
    logic [NREQ-1:0]      req       = '0;
    logic [NREQ*RW-1:0]   req_ratio = '0;
    logic [NREQ-1:0]      grant;
    logic                 locked;
    logic                 err_timeout;
    logic                 div_enable;
    logic [RW-1:0]        div_ratio;
    logic                 div_out   = 1'b0;
    logic                 stuck     = 1'b0;
    int unsigned          dcnt      = 0;

    int   n_tests   = 0;
    int   n_fail    = 0;
    logic seen_lock = 1'b0;
    logic seen_err  = 1'b0;

    always #5 clock = ~clock;

    clk_div_sched #(.NREQ(NREQ), .RW(RW), .TIMEOUT(TIMEOUT), .GUARD(GUARD)) dut (
        .clock(clock), .reset(reset), .req(req), .req_ratio(req_ratio),
        .grant(grant), .locked(locked), .err_timeout(err_timeout),
        .div_enable(div_enable), .div_ratio(div_ratio), .div_out(div_out)
    );

    // Divider: toggles every div_ratio+1 enabled cycles, holds while disabled or stuck.
    always @(posedge clock) begin
        if (div_enable && !stuck) begin
            if (dcnt >= 32'(div_ratio)) begin
                div_out <= ~div_out;
                dcnt    <= 0;
            end else begin
                dcnt <= dcnt + 1;
            end
        end else if (!div_enable) begin
            dcnt <= 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
        seen_lock = seen_lock | locked;
        seen_err  = seen_err | err_timeout;
        n_tests++;
        if (!$onehot0(grant)) begin
            n_fail++; $display("FAIL inv_onehot: grant=%b expected at most one bit", grant);
        end
        n_tests++;
        if (locked && grant == '0) begin
            n_fail++; $display("FAIL inv_locked: locked=%b grant=%b expected grant nonzero", locked, grant);
        end
        n_tests++;
        if (div_enable && grant == '0) begin
            n_fail++; $display("FAIL inv_enable: div_enable=%b grant=%b expected grant nonzero", div_enable, grant);
        end
    endtask

    // which: 0 grant nonzero, 1 locked, 2 err_timeout, 3 div_out change. cyc=-1 if bound expires.
    task automatic wait_sig(input int which, input int bound, output int cyc);
        logic d0;
        logic hit;
        d0  = div_out;
        cyc = -1;
        for (int i = 1; i <= bound && cyc < 0; i++) begin
            tick();
            case (which)
                0:       hit = (grant != '0);
                1:       hit = locked;
                2:       hit = err_timeout;
                default: hit = (div_out != d0);
            endcase
            if (hit) cyc = i;
        end
    endtask

    task automatic set_ratio(input int i, input logic [RW-1:0] v);
        req_ratio[i*RW +: RW] = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        stuck = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = '0;
        tick(); tick();
        n_tests++;
        if (grant !== '0 || locked !== 1'b0 || err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctl: grant=%b locked=%b err=%b expected 0", grant, locked, err_timeout);
        end
        n_tests++;
        if (div_enable !== 1'b0 || div_ratio !== '0) begin
            n_fail++; $display("FAIL reset_div: en=%b ratio=%0d expected 0", div_enable, div_ratio);
        end
        reset = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (grant !== '0 || div_enable !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: grant=%b en=%b expected 0", grant, div_enable);
        end
    endtask

    task automatic test_single();
        int cyc;
        do_reset();
        set_ratio(0, 9'd3);
        req = 2'b01;
        tick();
        n_tests++;
        if (grant !== 2'b00) begin
            n_fail++; $display("FAIL single_early: grant=%b expected 00", grant);
        end
        tick();
        n_tests++;
        if (grant !== 2'b01 || div_ratio !== 9'd3 || div_enable !== 1'b1) begin
            n_fail++; $display("FAIL single_grant: grant=%b ratio=%0d en=%b expected 01 3 1", grant, div_ratio, div_enable);
        end
        wait_sig(1, 50, cyc);
        n_tests++;
        if (cyc != 5) begin
            n_fail++; $display("FAIL single_lock: got %0d cycles expected 5", cyc);
        end
        wait_sig(3, 20, cyc);
        for (int h = 0; h < 2; h++) begin
            wait_sig(3, 20, cyc);
            n_tests++;
            if (cyc != 4) begin
                n_fail++; $display("FAIL single_halfperiod: got %0d cycles expected 4", cyc);
            end
        end
        repeat (16) tick();
        req = 2'b00;
        tick();
        n_tests++;
        if (div_enable !== 1'b0 || grant !== 2'b00 || locked !== 1'b0) begin
            n_fail++; $display("FAIL single_release: en=%b grant=%b locked=%b expected 0", div_enable, grant, locked);
        end
        repeat (GUARD) tick();
        n_tests++;
        if (div_enable !== 1'b0 || grant !== 2'b00) begin
            n_fail++; $display("FAIL single_guard: en=%b grant=%b expected 0", div_enable, grant);
        end
    endtask

    task automatic test_rotation();
        int cyc;
        do_reset();
        set_ratio(0, 9'd2);
        set_ratio(1, 9'd5);
        req = 2'b11;
        tick(); tick();
        n_tests++;
        if (grant !== 2'b01 || div_ratio !== 9'd2) begin
            n_fail++; $display("FAIL rot_first: grant=%b ratio=%0d expected 01 2", grant, div_ratio);
        end
        wait_sig(1, 50, cyc);
        n_tests++;
        if (cyc != 4) begin
            n_fail++; $display("FAIL rot_lock0: got %0d expected 4", cyc);
        end
        repeat (5) tick();
        req = 2'b10;
        tick();
        repeat (GUARD + 1) tick();
        n_tests++;
        if (grant !== 2'b00) begin
            n_fail++; $display("FAIL rot_gap: grant=%b expected 00", grant);
        end
        tick();
        n_tests++;
        if (grant !== 2'b10 || div_ratio !== 9'd5) begin
            n_fail++; $display("FAIL rot_second: grant=%b ratio=%0d expected 10 5", grant, div_ratio);
        end
        wait_sig(1, 50, cyc);
        n_tests++;
        if (cyc != 7) begin
            n_fail++; $display("FAIL rot_lock1: got %0d expected 7", cyc);
        end
        repeat (3) tick();
        req = 2'b01;
        tick();
        repeat (GUARD + 2) tick();
        n_tests++;
        if (grant !== 2'b01 || div_ratio !== 9'd2) begin
            n_fail++; $display("FAIL rot_back: grant=%b ratio=%0d expected 01 2", grant, div_ratio);
        end
        req = 2'b00;
        tick();
        repeat (GUARD + 2) tick();
    endtask

    task automatic test_timeout();
        int cyc;
        do_reset();
        stuck = 1'b1;
        set_ratio(0, 9'd0);
        req = 2'b01;
        tick(); tick();
        n_tests++;
        if (grant !== 2'b01) begin
            n_fail++; $display("FAIL to_grant: grant=%b expected 01", grant);
        end
        seen_lock = 1'b0;
        wait_sig(2, int'(TIMEOUT) + 50, cyc);
        n_tests++;
        if (cyc != int'(TIMEOUT)) begin
            n_fail++; $display("FAIL to_latency: got %0d expected %0d", cyc, TIMEOUT);
        end
        n_tests++;
        if (grant !== 2'b00 || div_enable !== 1'b0 || seen_lock !== 1'b0) begin
            n_fail++; $display("FAIL to_stop: grant=%b en=%b lock_seen=%b expected 0", grant, div_enable, seen_lock);
        end
        tick();
        n_tests++;
        if (err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL to_pulse: err=%b expected 0", err_timeout);
        end
        repeat (GUARD) tick();
        n_tests++;
        if (grant !== 2'b00) begin
            n_fail++; $display("FAIL to_guard: grant=%b expected 00", grant);
        end
        tick();
        n_tests++;
        if (grant !== 2'b01) begin
            n_fail++; $display("FAIL to_regrant: grant=%b expected 01", grant);
        end
        req   = 2'b00;
        stuck = 1'b0;
        tick();
        repeat (GUARD + 2) tick();
    endtask

    task automatic test_release_start();
        do_reset();
        set_ratio(0, 9'd200);
        req = 2'b01;
        tick(); tick();
        n_tests++;
        if (grant !== 2'b01 || div_enable !== 1'b1) begin
            n_fail++; $display("FAIL rs_grant: grant=%b en=%b expected 01 1", grant, div_enable);
        end
        seen_lock = 1'b0;
        seen_err  = 1'b0;
        repeat (9) tick();
        req = 2'b00;
        tick();
        n_tests++;
        if (grant !== 2'b00 || div_enable !== 1'b0) begin
            n_fail++; $display("FAIL rs_stop: grant=%b en=%b expected 0", grant, div_enable);
        end
        repeat (GUARD + 5) tick();
        n_tests++;
        if (seen_err !== 1'b0 || seen_lock !== 1'b0) begin
            n_fail++; $display("FAIL rs_flags: err_seen=%b lock_seen=%b expected 0", seen_err, seen_lock);
        end
    endtask

    task automatic test_ratio_change();
        int cyc;
        do_reset();
        set_ratio(0, 9'd3);
        req = 2'b01;
        tick(); tick();
        wait_sig(1, 50, cyc);
        set_ratio(0, 9'd7);
        repeat (10) tick();
        n_tests++;
        if (div_ratio !== 9'd3 || locked !== 1'b1) begin
            n_fail++; $display("FAIL rc_frozen: ratio=%0d locked=%b expected 3 1", div_ratio, locked);
        end
        req = 2'b00;
        tick();
        repeat (GUARD) tick();
        req = 2'b01;
        tick(); tick();
        n_tests++;
        if (grant !== 2'b01 || div_ratio !== 9'd7) begin
            n_fail++; $display("FAIL rc_reload: grant=%b ratio=%0d expected 01 7", grant, div_ratio);
        end
        wait_sig(1, 50, cyc);
        n_tests++;
        if (cyc != 9) begin
            n_fail++; $display("FAIL rc_lock: got %0d expected 9", cyc);
        end
    endtask

    // Continues from the locked owner left by test_ratio_change.
    task automatic test_reset_mid_run();
        int cyc;
        reset = 1'b1;
        tick();
        n_tests++;
        if (grant !== '0 || locked !== 1'b0 || div_enable !== 1'b0 || div_ratio !== '0 || err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL rst_run: grant=%b locked=%b en=%b ratio=%0d err=%b expected 0",
                               grant, locked, div_enable, div_ratio, err_timeout);
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if (grant !== 2'b00) begin
            n_fail++; $display("FAIL rst_early: grant=%b expected 00", grant);
        end
        tick();
        n_tests++;
        if (grant !== 2'b01) begin
            n_fail++; $display("FAIL rst_regrant: grant=%b expected 01", grant);
        end
        wait_sig(1, 50, cyc);
        req = 2'b00;
        tick();
        repeat (GUARD + 2) tick();
    endtask

    task automatic test_random();
        int              ptr;
        int              win;
        int              cyc;
        logic [NREQ-1:0] pat;
        logic [RW-1:0]   rat [NREQ];
        logic [RW-1:0]   frozen;
        do_reset();
        ptr = 0;
        for (int i = 0; i < NR; i++) begin
            rat[i] = RW'($urandom_range(0, 20));
            set_ratio(i, rat[i]);
        end
        pat = NREQ'($urandom_range(1, (1 << NR) - 1));
        req = pat;
        tick(); tick();
        for (int round = 0; round < 40; round++) begin
            win = -1;
            for (int k = 0; k < NR; k++)
                if (win < 0 && pat[(ptr + k) % NR]) win = (ptr + k) % NR;
            n_tests++;
            if (grant !== NREQ'(1 << win)) begin
                n_fail++; $display("FAIL rnd_grant: round %0d grant=%b expected owner %0d", round, grant, win);
            end
            n_tests++;
            if (div_ratio !== rat[win]) begin
                n_fail++; $display("FAIL rnd_ratio: round %0d got %0d expected %0d", round, div_ratio, rat[win]);
            end
            frozen = rat[win];
            wait_sig(1, 64, cyc);
            n_tests++;
            if (cyc != int'(rat[win]) + 2) begin
                n_fail++; $display("FAIL rnd_lock: round %0d got %0d expected %0d", round, cyc, int'(rat[win]) + 2);
            end
            repeat ($urandom_range(0, 8)) tick();
            if ($urandom_range(0, 1) == 1) begin
                rat[win] = RW'($urandom_range(0, 20));
                set_ratio(win, rat[win]);
            end
            tick();
            n_tests++;
            if (div_ratio !== frozen || locked !== 1'b1) begin
                n_fail++; $display("FAIL rnd_hold: round %0d ratio=%0d locked=%b expected %0d 1", round, div_ratio, locked, frozen);
            end
            pat = NREQ'($urandom) & ~NREQ'(1 << win);
            req = pat;
            tick();
            n_tests++;
            if (grant !== '0 || div_enable !== 1'b0) begin
                n_fail++; $display("FAIL rnd_release: round %0d grant=%b en=%b expected 0", round, grant, div_enable);
            end
            ptr = (win + 1) % NR;
            pat = pat | NREQ'($urandom);
            if (pat == '0) pat = NREQ'(1 << $urandom_range(0, NR - 1));
            req = pat;
            for (int i = 0; i < NR; i++) begin
                rat[i] = RW'($urandom_range(0, 20));
                set_ratio(i, rat[i]);
            end
            repeat (GUARD) tick();
            n_tests++;
            if (grant !== '0) begin
                n_fail++; $display("FAIL rnd_guard: round %0d grant=%b expected 0", round, grant);
            end
            tick(); tick();
        end
        req = '0;
        tick();
        repeat (GUARD + 2) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_release_start();
        test_ratio_change();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
